// File: rtl/apu_mix_pkg.sv
// Shared types, constants and the DAC helper for the APU stereo mixer.
package apu_mix_pkg;

  localparam int DAC_BIAS = 15;
  localparam int MAX_VOL  = 7;

  typedef logic signed [5:0] dac_t;
  typedef logic signed [7:0] acc_t;

  typedef enum logic [3:0] {
    IDLE,
    SNAP,
    ACC1,
    ACC2,
    ACC3,
    ACC4,
    ACCV,
    SCALE,
    PUSH
  } mix_state_t;

  // Disabled channels contribute silence; enabled ones are centred on zero.
  function automatic dac_t dac_of(input logic [3:0] code, input logic nactive);
    if (nactive) return '0;
    return dac_t'({1'b0, code, 1'b0}) - dac_t'(DAC_BIAS);
  endfunction

endpackage

// File: rtl/apu_mix_fifo.sv
// Dual-pointer sample buffer; the head output falls back to the last popped entry when empty.
module apu_mix_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wPtr_q, rPtr_q, lastPtr;
  logic [PW:0]   count_q;
  logic          pushOk, popOk;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign popOk   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign pushOk  = push_i && (!full_o || popOk);
  assign lastPtr = rPtr_q - PW'(1);
  assign data_o  = empty_o ? mem_q[lastPtr] : mem_q[rPtr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wPtr_q  <= '0;
      rPtr_q  <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        mem_q[wPtr_q] <= data_i;
        wPtr_q        <= wPtr_q + PW'(1);
      end
      if (popOk) rPtr_q <= rPtr_q + PW'(1);
      if (pushOk && !popOk)      count_q <= count_q + (PW+1)'(1);
      else if (popOk && !pushOk) count_q <= count_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/apu_stereo_mixer.sv
// Serial four-channel stereo mixer with master volume and an output sample buffer.
// Defining APU_MIX_VIN_EN adds the external VIN input as a fifth accumulation step.
module apu_stereo_mixer
  import apu_mix_pkg::*;
#(
  parameter int OUT_W      = 11,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             apuv_4mhz,
  input  logic             napu_reset,
  input  logic             smp_tick,
  input  logic [3:0]       ch1_code,
  input  logic [3:0]       ch2_code,
  input  logic [3:0]       ch3_code,
  input  logic [3:0]       ch4_code,
  input  logic             nch1_active,
  input  logic             nch2_active,
  input  logic             nch3_active,
  input  logic             nch4_active,
  input  logic [3:0]       rmixer,
  input  logic [3:0]       lmixer,
  input  logic [2:0]       nrvolume,
  input  logic [2:0]       nlvolume,
  input  logic             vin_r_ena,
  input  logic             vin_l_ena,
  input  logic [3:0]       vin_code,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  mix_state_t              state_q;
  logic [3:0]              rMix_q, lMix_q;
  logic [2:0]              volR_q, volL_q;
  acc_t                    accL_q, accR_q, dExt;
  logic signed [OUT_W-1:0] smpL_q, smpR_q;
  logic signed [OUT_W-1:0] accLExt, accRExt, volLMul, volRMul;
  logic                    overrun_q;
  dac_t                    dSel;
  logic                    rSel, lSel;
  logic                    pushEn, popEn, fifoFull, fifoEmpty, overrunSet;
  logic [2*OUT_W-1:0]      headData;

`ifdef APU_MIX_VIN_EN
  logic vinR_q, vinL_q;

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      vinR_q <= 1'b0;
      vinL_q <= 1'b0;
    end else if (state_q == SNAP) begin
      vinR_q <= vin_r_ena;
      vinL_q <= vin_l_ena;
    end
  end
`else
  logic unused_vin;
  assign unused_vin = ^{vin_code, vin_r_ena, vin_l_ena};
`endif

  // One source per accumulation step, routed by the snapshotted enables.
  always_comb begin
    dSel = '0;
    rSel = 1'b0;
    lSel = 1'b0;
    case (state_q)
      ACC1: begin dSel = dac_of(ch1_code, nch1_active); rSel = rMix_q[0]; lSel = lMix_q[0]; end
      ACC2: begin dSel = dac_of(ch2_code, nch2_active); rSel = rMix_q[1]; lSel = lMix_q[1]; end
      ACC3: begin dSel = dac_of(ch3_code, nch3_active); rSel = rMix_q[2]; lSel = lMix_q[2]; end
      ACC4: begin dSel = dac_of(ch4_code, nch4_active); rSel = rMix_q[3]; lSel = lMix_q[3]; end
`ifdef APU_MIX_VIN_EN
      ACCV: begin dSel = dac_of(vin_code, 1'b0); rSel = vinR_q; lSel = vinL_q; end
`endif
      default: ;
    endcase
  end

  assign dExt    = acc_t'({{2{dSel[5]}}, dSel});
  assign accLExt = {{(OUT_W-8){accL_q[7]}}, accL_q};
  assign accRExt = {{(OUT_W-8){accR_q[7]}}, accR_q};
  assign volLMul = OUT_W'({1'b0, volL_q} + 4'd1);
  assign volRMul = OUT_W'({1'b0, volR_q} + 4'd1);

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      state_q <= IDLE;
      rMix_q  <= '0;
      lMix_q  <= '0;
      volR_q  <= '0;
      volL_q  <= '0;
      accL_q  <= '0;
      accR_q  <= '0;
      smpL_q  <= '0;
      smpR_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (smp_tick) state_q <= SNAP;
        SNAP: begin
          rMix_q  <= rmixer;
          lMix_q  <= lmixer;
          volR_q  <= ~nrvolume;
          volL_q  <= ~nlvolume;
          accL_q  <= '0;
          accR_q  <= '0;
          state_q <= ACC1;
        end
        ACC1: state_q <= ACC2;
        ACC2: state_q <= ACC3;
        ACC3: state_q <= ACC4;
`ifdef APU_MIX_VIN_EN
        ACC4: state_q <= ACCV;
        ACCV: state_q <= SCALE;
`else
        ACC4: state_q <= SCALE;
`endif
        SCALE: begin
          smpL_q  <= accLExt * volLMul;
          smpR_q  <= accRExt * volRMul;
          state_q <= PUSH;
        end
        PUSH:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (rSel) accR_q <= accR_q + dExt;
      if (lSel) accL_q <= accL_q + dExt;
    end
  end

  assign pushEn     = (state_q == PUSH);
  assign popEn      = out_valid && out_ready;
  assign overrunSet = (smp_tick && state_q != IDLE) || (pushEn && fifoFull && !popEn);

  // A new loss event outranks a clear arriving in the same cycle.
  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset)      overrun_q <= 1'b0;
    else if (overrunSet)  overrun_q <= 1'b1;
    else if (overrun_clr) overrun_q <= 1'b0;
  end

  apu_mix_fifo #(
    .W     (2*OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (apuv_4mhz),
    .rst_ni  (napu_reset),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  ({smpL_q, smpR_q}),
    .data_o  (headData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_l     = headData[2*OUT_W-1:OUT_W];
  assign out_r     = headData[OUT_W-1:0];
  assign out_valid = !fifoEmpty;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: doc/apu_stereo_mixer.md
Name: apu_stereo_mixer

Overview:
- Consumer side of the APU control register block: takes the NR51 routing (rmixer/lmixer), the NR50 volumes (nrvolume/nlvolume, active-low encoded) and the VIN enables as that block drives them.
- Combines the four channel DAC codes into signed left/right samples, once per sample tick.
- A small state machine accumulates the channels serially, scales by master volume, and pushes L/R pairs into an output buffer drained with a valid/ready handshake.
- Sits between the channel generators and the analog-model/WAV-dump back end.

Parameters:
- OUT_W, 11, signed output sample width; minimum 11, wider values sign-extend.
- FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
- apuv_4mhz  input  1  APU clock; all state updates on its rising edge.
- napu_reset  input  1  asynchronous active-low reset.
- smp_tick  input  1  one-cycle sample request.
- ch1_code, ch2_code, ch3_code, ch4_code  input  4 each  channel DAC codes, 0..15.
- nch1_active, nch2_active, nch3_active, nch4_active  input  1 each  active-low channel-on flags.
- rmixer  input  4  NR51 right enables; bit n = channel n+1.
- lmixer  input  4  NR51 left enables; bit n = channel n+1.
- nrvolume  input  3  inverted NR50 right volume.
- nlvolume  input  3  inverted NR50 left volume.
- vin_r_ena, vin_l_ena  input  1 each  NR50 VIN routing.
- vin_code  input  4  external VIN DAC code (used only with the optional feature).
- out_l, out_r  output  OUT_W  signed samples at the buffer head.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts the head entry when out_valid && out_ready.
- busy  output  1  FSM not in IDLE.
- overrun  output  1  sticky: a tick or a push was lost.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, napu_reset low):
  - FSM to IDLE; buffer emptied.
  - out_l = out_r = 0, out_valid = 0, busy = 0, overrun = 0.
  - Accumulators and snapshot registers cleared.
- Per-channel DAC value: d = 2*code - 15 when its n*_active is low, otherwise 0. Range -15..+15, 6-bit signed.
- FSM states: IDLE -> SNAP -> ACC1 -> ACC2 -> ACC3 -> ACC4 -> [ACCV] -> SCALE -> PUSH -> IDLE.
- IDLE: smp_tick = 1 moves to SNAP.
- SNAP: copies rmixer, lmixer, ~nrvolume, ~nlvolume and the VIN enables into shadow registers, and zeroes acc_l/acc_r. Register writes arriving mid-sample do not affect the sample in progress.
- ACCn: acc_r += d_n if shadow rmixer[n-1]; acc_l += d_n if shadow lmixer[n-1]. Both use 8-bit signed accumulators (range ±75).
- ACCV: exists only with the optional feature; otherwise ACC4 goes directly to SCALE.
- SCALE: out = acc * (vol + 1), with vol = ~n*volume (0..7). Worst case ±600, fits 11 bits signed, so no saturation is needed.
- PUSH: writes the {L,R} pair into the buffer.
  - If the buffer is full, the pair is dropped and overrun is set.
  - A simultaneous pop frees a slot, so the push succeeds.
- Latency with an empty buffer:
  - tick sampled at cycle t; SNAP at t+1; ACC1..4 at t+2..t+5; SCALE at t+6; PUSH at t+7; out_valid = 1 from t+8.
  - The VIN build adds 1 cycle.
- smp_tick while busy: ignored and overrun is set. A tick in the same cycle as PUSH also counts as busy.
- overrun: overrun_clr clears it. If overrun_clr and a new overrun event occur in the same cycle, the set wins.
- Buffer:
  - FIFO order.
  - out_l/out_r show the head entry; they hold their last values when empty.
  - out_valid deasserts the cycle after the last pop.
  - Simultaneous push and pop leave the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- APU_MIX_VIN_EN defined:
  - Adds the ACCV state and the VIN path.
  - In ACCV, d_v = 2*vin_code - 15 is added to acc_r if vin_r_ena and to acc_l if vin_l_ena (values as snapshotted).
  - Latency becomes 9 cycles.
- Undefined: vin_code, vin_r_ena and vin_l_ena are ignored and latency is 8.

Decomposition:
- Shared package apu_mix_pkg holds:
  - the mix_state_t enum;
  - DAC_BIAS = 15 and MAX_VOL = 7;
  - typedef dac_t (6-bit signed) and typedef acc_t (8-bit signed);
  - function dac_of(code, nactive).
- One sub-module: apu_mix_fifo, the parameterized dual-pointer sample buffer with full/empty flags.

Test Plan:
- Routing and volume, single channel: ch1_code = 15, nch1_active = 0, others inactive, rmixer = 0001, lmixer = 0000, nrvolume = 000, nlvolume = 111, one tick -> out_r = 120, out_l = 0, out_valid at t+8.
- Full-scale negative: all codes 0, all active, rmixer = lmixer = 1111, volumes 000 -> out_l = out_r = -480. All codes 15 -> +480.
- Snapshot isolation: change rmixer 1111 -> 0000 at t+3 -> sample still uses 1111; the next tick uses 0000.
- Buffer and overrun:
  - out_ready = 0; three ticks spaced 10 cycles apart -> two entries held, third dropped, overrun = 1.
  - Then pop both in order -> out_valid falls; overrun_clr -> overrun = 0.
- Busy tick and reset: tick at t and again at t+4 -> one sample produced, overrun = 1. Assert napu_reset low during ACC2 -> all outputs 0 immediately, no sample emitted.
- VIN (APU_MIX_VIN_EN): vin_code = 15, vin_l_ena = 1, channels inactive, nlvolume = 110 -> out_l = 30, out_r = 0, out_valid at t+9.
